count_job_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one down-counter among N_REQ requesters. Each requester asks for a counting job of programmable length. The block grants one requester at a time, runs the shared counter for that requester's length, and signals completion with a Mealy done pulse back to the winner. It sits between the per-channel go/done control FSMs and the single timing counter resource.

---
 rtl/count_job_arbiter_pkg.sv | 15 +
 rtl/count_job_arbiter_if.sv | 30 +++
 rtl/count_job_arbiter_rr_pick.sv | 40 ++++
 rtl/count_job_arbiter.sv | 97 +++++++++
 tb/tb_count_job_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/count_job_arbiter_pkg.sv
// Shared types for the count-job arbiter: FSM state encoding and the
// helper that sizes requester indices.
package count_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/count_job_arbiter_if.sv
// Requester-side bundle of the count-job arbiter: per-channel requests and
// lengths in, grant/status/counter/done back out.
interface count_job_arbiter_if
  import count_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4
) ();

  localparam int ID_W = id_width(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] len;
  logic [N_REQ-1:0]       grant;
  logic [ID_W-1:0]        grant_id;
  logic                   busy;
  logic [CNT_W-1:0]       count;
  logic [N_REQ-1:0]       done;

  modport master (
    output req, len,
    input  grant, grant_id, busy, count, done
  );

  modport slave (
    input  req, len,
    output grant, grant_id, busy, count, done
  );

endinterface

// File: rtl/count_job_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping modulo N_REQ.
module rr_pick
  import count_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic             o_valid,
  output logic [ID_W-1:0]  o_idx,
  output logic [N_REQ-1:0] o_onehot
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_cand;

  always_comb begin
    // NOTE: every output and temporary gets a default first, so no path
    // through the loop leaves a value held and no latch is inferred.
    o_valid  = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    w_sum    = '0;
    w_cand   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_sum  = {1'b0, i_ptr} + (ID_W + 1)'(i);
      w_cand = (w_sum >= (ID_W + 1)'(N_REQ)) ? ID_W'(w_sum - (ID_W + 1)'(N_REQ))
                                             : ID_W'(w_sum);
      if (!o_valid && i_req[w_cand]) begin
        o_valid          = 1'b1;
        o_idx            = w_cand;
        o_onehot[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/count_job_arbiter.sv
// Round-robin arbiter that lends one shared down-counter to N_REQ requesters
// and returns a Mealy done pulse to the winner when its count reaches zero.
module count_job_arbiter
  import count_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4
) (
  input logic          clk,
  input logic          rst_n,
  count_job_arbiter_if.slave bus
);

  localparam int              ID_W    = id_width(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  state_t           r_state;
  logic [N_REQ-1:0] r_grant;
  logic [ID_W-1:0]  r_grant_id;
  logic [ID_W-1:0]  r_ptr;
  logic             r_busy;
  logic [CNT_W-1:0] r_count;

  logic             w_pick_valid;
  logic [ID_W-1:0]  w_pick_idx;
  logic [N_REQ-1:0] w_pick_onehot;
  logic [CNT_W-1:0] w_len [N_REQ];
  logic             w_cur_req;
  logic             w_terminal;
  logic [ID_W-1:0]  w_next_ptr;

  for (genvar g = 0; g < N_REQ; g++) begin : g_len
    assign w_len[g] = bus.len[g*CNT_W +: CNT_W];
  end

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_valid  (w_pick_valid),
    .o_idx    (w_pick_idx),
    .o_onehot (w_pick_onehot)
  );

  // An owner that drops its request aborts the job; abort beats completion.
  assign w_cur_req  = bus.req[r_grant_id];
  assign w_terminal = (r_state == RUN) && w_cur_req && (r_count == '0);
  assign w_next_ptr = (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every register
    // sees the pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_ptr      <= '0;
      r_busy     <= 1'b0;
      r_count    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_grant    <= w_pick_onehot;
            r_grant_id <= w_pick_idx;
            r_count    <= w_len[w_pick_idx];
            r_busy     <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          if (!w_cur_req || r_count == '0) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_next_ptr;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_grant    <= '0;
          r_grant_id <= '0;
          r_busy     <= 1'b0;
          r_count    <= '0;
        end
      endcase
    end
  end

  assign bus.grant    = r_grant;
  assign bus.grant_id = r_grant_id;
  assign bus.busy     = r_busy;
  assign bus.count    = r_count;
  assign bus.done     = w_terminal ? r_grant : '0;

endmodule

// File: tb/tb_count_job_arbiter.sv
// Scoreboard bench for count_job_arbiter: expected jobs are queued as
// stimulus is driven and checked cycle by cycle as the DUT runs them.
module tb_count_job_arbiter;
  import count_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 4;

  typedef struct {
    int id;
    int len;
    int gap;
  } job_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  count_job_arbiter_if #(.N_REQ(N), .CNT_W(W)) bus ();

  count_job_arbiter #(.N_REQ(N), .CNT_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  job_t exp_q[$];

  bit m_run      = 1'b0;
  bit m_endchk   = 1'b0;
  int m_id       = 0;
  int m_count    = 0;
  int m_cyc      = 0;
  int m_last_start = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_job(input int id, input int len, input int gap);
    job_t e;
    e.id  = id;
    e.len = len;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Reference model of the running job, advanced on the falling edge.
  always @(negedge clk) begin
    job_t         e;
    logic [N-1:0] exp_done;
    m_cyc++;
    if (!rst_n) begin
      m_run    = 1'b0;
      m_endchk = 1'b0;
      check("rst_done", 32'(bus.done), 32'(0));
    end else begin
      if (m_endchk) begin
        check("end_busy", 32'(bus.busy), 32'(0));
        check("end_grant", 32'(bus.grant), 32'(0));
        m_endchk = 1'b0;
      end else if (!m_run && bus.busy) begin
        if (exp_q.size() == 0) begin
          check("spurious_grant", 32'(bus.busy), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("grant_id", 32'(bus.grant_id), 32'(e.id));
          if (e.gap > 0) check("job_gap", 32'(m_cyc - m_last_start), 32'(e.gap));
          m_last_start = m_cyc;
          m_run   = 1'b1;
          m_id    = e.id;
          m_count = e.len;
        end
      end
      if (m_run) begin
        exp_done = (m_count == 0 && bus.req[m_id]) ? (N'(1) << m_id) : '0;
        check("busy", 32'(bus.busy), 32'(1));
        check("grant", 32'(bus.grant), 32'(N'(1) << m_id));
        check("count", 32'(bus.count), 32'(m_count));
        check("done", 32'(bus.done), 32'(exp_done));
        if (exp_done != '0 || !bus.req[m_id]) begin
          m_run    = 1'b0;
          m_endchk = 1'b1;
        end else begin
          m_count--;
        end
      end else begin
        check("idle_done", 32'(bus.done), 32'(0));
      end
    end
  end

  // Wait for all queued jobs to finish, then drop every request before the
  // next edge so no extra job is started.
  task automatic drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || m_run) && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("drain_timeout", 32'(exp_q.size() != 0 || m_run), 32'(0));
    #1 bus.req = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input int value, input int budget);
    int k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!(bus.busy && bus.count == W'(value)) && k < budget);
    check("reach_count", 32'(bus.busy && bus.count == W'(value)), 32'(1));
  endtask

  initial begin
    bus.req = '0;
    bus.len = '0;

    #12;
    check("rst_grant", 32'(bus.grant), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_count", 32'(bus.count), 32'(0));
    check("rst_grant_id", 32'(bus.grant_id), 32'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single job on ch0, length 3.
    @(posedge clk);
    #1;
    bus.len = 16'h0003;
    push_job(0, 3, 0);
    bus.req = 4'b0001;
    @(posedge clk);
    #1 check("req_to_grant", 32'(bus.grant), 32'(4'b0001));
    drain(20);

    // Fairness from a fresh pointer: all requesting, zero-length jobs.
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.len = '0;
    push_job(0, 0, 0);
    push_job(1, 0, 2);
    push_job(2, 0, 2);
    push_job(3, 0, 2);
    push_job(0, 0, 2);
    bus.req = 4'b1111;
    drain(40);

    // Pointer skip: a job on ch1 leaves ptr=2, so ch0 wins over ch1.
    push_job(1, 0, 0);
    bus.req = 4'b0010;
    drain(20);
    bus.len = 16'h0002;
    push_job(0, 2, 0);
    bus.req = 4'b0011;
    drain(20);

    // Abort ch2 mid-count; the pointer must still advance to 3.
    bus.len = 16'h0500;
    push_job(2, 5, 0);
    bus.req = 4'b0100;
    wait_count(2, 20);
    bus.req = '0;
    drain(20);
    bus.len = '0;
    push_job(3, 0, 0);
    bus.req = 4'b1111;
    drain(20);

    // Abort on the terminal cycle: no done may appear.
    bus.len = 16'h0020;
    push_job(1, 2, 0);
    bus.req = 4'b0010;
    wait_count(0, 20);
    bus.req = '0;
    drain(20);

    // Reset mid-job, then arbitration must restart from ch0.
    bus.len = 16'h0007;
    push_job(0, 7, 0);
    bus.req = 4'b0001;
    wait_count(4, 20);
    rst_n = 1'b0;
    #1;
    check("midrst_grant", 32'(bus.grant), 32'(0));
    check("midrst_busy", 32'(bus.busy), 32'(0));
    check("midrst_count", 32'(bus.count), 32'(0));
    check("midrst_grant_id", 32'(bus.grant_id), 32'(0));
    check("midrst_done", 32'(bus.done), 32'(0));
    bus.len = '0;
    bus.req = 4'b1111;
    repeat (2) @(posedge clk);
    #2;
    push_job(0, 0, 0);
    rst_n = 1'b1;
    drain(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
